// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the pipeline and the memory arbiter.
package cpu_types_pkg;

  // Machine word: addresses and data are both 32 bits wide.
  typedef logic [31:0] word_t;

  // Status reported by the RAM for the access currently presented to it.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter ownership of the single RAM port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Word handed back to a requester whose access ended in a RAM error.
  localparam word_t LOAD_ERR_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the IF fetch requester and the
// MEM data requester. Data has priority and only one access is in flight.
// Each requester sees a wait line that drops for exactly its completion cycle.
// Optional feature macro: ARB_STARVE_GUARD_EN -- after MAX_DBURST consecutive
// data grants taken while a fetch is pending, the fetch wins once.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4,
  parameter word_t       LOAD_ERR   = LOAD_ERR_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  // A burst limit of zero would make the guard meaningless.
  if (MAX_DBURST < 1) begin : g_bad_burst
    $error("memory_arbiter: MAX_DBURST must be at least 1");
  end

  arb_state_t state_reg;
  arb_state_t state_next;
  word_t      addr_reg;
  word_t      data_reg;
  logic       wr_reg;

  logic  d_req;
  logic  take_d;
  logic  take_i;
  logic  fetch_first;
  logic  ram_err;
  logic  ram_done;
  word_t load_word;

  // dREN and dWEN together count as a single write request.
  assign d_req     = dREN | dWEN;
  assign ram_err   = (ramstate == ERROR);
  assign ram_done  = (ramstate == ACCESS) || ram_err;
  assign load_word = ram_err ? LOAD_ERR : ramload;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_DBURST + 1);

  logic [CNT_W-1:0] streak_reg;

  assign fetch_first = iREN && (streak_reg == CNT_W'(MAX_DBURST));

  // Count data grants that overtook a pending fetch; any fetch grant or an
  // idle cycle without a fetch request restarts the count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_reg <= '0;
    end else if (take_i || (state_reg == IDLE && !iREN)) begin
      streak_reg <= '0;
    end else if (take_d && iREN && (streak_reg != CNT_W'(MAX_DBURST))) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the winning request in IDLE; the RAM sees only these copies
  // while granted, so requester inputs may change freely during the access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_reg <= '0;
      data_reg <= '0;
      wr_reg   <= 1'b0;
    end else if (take_d) begin
      addr_reg <= daddr;
      data_reg <= dstore;
      wr_reg   <= dWEN;
    end else if (take_i) begin
      addr_reg <= iaddr;
      data_reg <= '0;
      wr_reg   <= 1'b0;
    end
  end

  // Arbitration, RAM drive, completion/abort handling and requester outputs.
  always_comb begin
    state_next = state_reg;
    take_d     = 1'b0;
    take_i     = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    memerr     = 1'b0;

    if (state_reg != IDLE) begin
      ramREN   = !wr_reg;
      ramWEN   = wr_reg;
      ramaddr  = addr_reg;
      ramstore = data_reg;
    end

    unique case (state_reg)
      IDLE: begin
        if (d_req && !fetch_first) begin
          take_d     = 1'b1;
          state_next = DGRANT;
        end else if (iREN) begin
          take_i     = 1'b1;
          state_next = IGRANT;
        end
      end
      IGRANT: begin
        // A dropped request abandons the access without a completion.
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_done) begin
          iwait      = 1'b0;
          iload      = load_word;
          memerr     = ram_err;
          state_next = IDLE;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_next = IDLE;
        end else if (ram_done) begin
          dwait      = 1'b0;
          dload      = load_word;
          memerr     = ram_err;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic for
// memory_arbiter, checked cycle by cycle against a transaction-level model.
// Honours ARB_STARVE_GUARD_EN the same way the design does.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned MAX_DBURST = 4;
  localparam word_t       ERR_WORD   = 32'hBAD1BAD1;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  memory_arbiter #(
    .MAX_DBURST(MAX_DBURST)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the access currently owning the RAM (if any) and the
  // number of data grants that jumped ahead of a waiting fetch.
  bit    m_active;
  bit    m_is_data;
  bit    m_write;
  word_t m_addr;
  word_t m_data;
  int    m_streak;

  // Outputs sampled during the most recent step.
  logic  s_iwait, s_dwait, s_ren, s_wen, s_err;
  word_t s_iload, s_dload, s_addr, s_store;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hold reset for one cycle with whatever inputs are currently driven and
  // confirm every output is at its idle value while reset is asserted.
  task automatic do_reset();
    nRST = 1'b0;
    #2;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_memerr", 32'(memerr), 32'd0);
    m_active = 1'b0;
    m_streak = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  // Called at 1 time unit after a rising edge; returns at the same phase.
  task automatic step(input logic i_ren, input word_t i_addr, input logic d_ren,
                      input logic d_wen, input word_t d_addr, input word_t d_store,
                      input ramstate_t rs, input word_t rl);
    logic  e_iwait, e_dwait, e_ren, e_wen, e_err;
    word_t e_iload, e_dload, e_addr, e_store, ld;
    bit    held, fin, fetch_first;
    iREN = i_ren; iaddr = i_addr; dREN = d_ren; dWEN = d_wen;
    daddr = d_addr; dstore = d_store; ramstate = rs; ramload = rl;
    #3;
    s_iwait = iwait; s_dwait = dwait; s_ren = ramREN; s_wen = ramWEN; s_err = memerr;
    s_iload = iload; s_dload = dload; s_addr = ramaddr; s_store = ramstore;

    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0; e_err = 1'b0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    held = 1'b0; fin = 1'b0;
    ld = (rs == ERROR) ? ERR_WORD : rl;
    if (m_active) begin
      e_ren = !m_write; e_wen = m_write; e_addr = m_addr; e_store = m_data;
      held = m_is_data ? (d_ren || d_wen) : i_ren;
      fin = (rs == ACCESS) || (rs == ERROR);
      if (held && fin) begin
        if (m_is_data) begin
          e_dwait = 1'b0; e_dload = ld;
        end else begin
          e_iwait = 1'b0; e_iload = ld;
        end
        e_err = (rs == ERROR);
        $display("xfer %s %s addr=%h load=%h err=%0d", m_is_data ? "D" : "I",
                 m_write ? "wr" : "rd", m_addr, ld, e_err);
      end
    end

    check("iwait", 32'(s_iwait), 32'(e_iwait));
    check("dwait", 32'(s_dwait), 32'(e_dwait));
    check("iload", s_iload, e_iload);
    check("dload", s_dload, e_dload);
    check("ramREN", 32'(s_ren), 32'(e_ren));
    check("ramWEN", 32'(s_wen), 32'(e_wen));
    check("ramaddr", s_addr, e_addr);
    check("ramstore", s_store, e_store);
    check("memerr", 32'(s_err), 32'(e_err));

    if (m_active) begin
      if (!held || fin) m_active = 1'b0;
    end else begin
      fetch_first = GUARD && i_ren && (m_streak == int'(MAX_DBURST));
      if ((d_ren || d_wen) && !fetch_first) begin
        m_active = 1'b1; m_is_data = 1'b1; m_write = d_wen;
        m_addr = d_addr; m_data = d_store;
        if (i_ren && m_streak < int'(MAX_DBURST)) m_streak++;
      end else if (i_ren) begin
        m_active = 1'b1; m_is_data = 1'b0; m_write = 1'b0;
        m_addr = i_addr; m_data = '0;
        m_streak = 0;
      end
      if (!i_ren) m_streak = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic ramstate_t pick_rs();
    int v;
    v = int'($urandom_range(0, 7));
    if (v <= 2) return BUSY;
    if (v == 3) return FREE;
    if (v == 7) return ERROR;
    return ACCESS;
  endfunction

  initial begin
    int first_low;
    int ren_cycles;
    int grants;
    int fetches;
    bit exp_fetch;
    bit r_i, r_d, r_w;

    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    m_active = 1'b0; m_is_data = 1'b0; m_write = 1'b0;
    m_addr = '0; m_data = '0; m_streak = 0;
    @(posedge CLK);
    #1;

    // Reset with both requests held: first grant goes to data right after.
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h700; daddr = 32'h600; ramstate = ACCESS;
    do_reset();
    step(1'b1, 32'h700, 1'b1, 1'b0, 32'h600, 32'h0, FREE, 32'h0);
    check("first_cycle_idle", 32'(s_ren), 32'd0);
    step(1'b1, 32'h700, 1'b1, 1'b0, 32'h600, 32'h0, BUSY, 32'h0);
    check("first_grant_ren", 32'(s_ren), 32'd1);
    check("first_grant_addr", s_addr, 32'h600);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    $display("scenario reset_priority done");

    // Fetch with two BUSY cycles: wait drops at cycle 4 of the request.
    do_reset();
    first_low = 0;
    ren_cycles = 0;
    for (int c = 1; c <= 6; c++) begin
      step(c <= 4, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0,
           (c == 4) ? ACCESS : ((c == 2 || c == 3) ? BUSY : FREE), 32'h8C220004);
      if (s_ren) ren_cycles++;
      if (!s_iwait && first_low == 0) begin
        first_low = c;
        check("fetch_iload", s_iload, 32'h8C220004);
      end
    end
    check("fetch_latency", 32'(first_low), 32'd4);
    check("fetch_ren_cycles", 32'(ren_cycles), 32'd3);
    $display("scenario fetch_latency done");

    // Write and fetch together: write first, one idle cycle, then the fetch.
    do_reset();
    step(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, FREE, 32'h0);
    step(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, ACCESS, 32'h0);
    check("wr_ramWEN", 32'(s_wen), 32'd1);
    check("wr_ramaddr", s_addr, 32'h200);
    check("wr_ramstore", s_store, 32'hDEADBEEF);
    check("wr_dwait", 32'(s_dwait), 32'd0);
    check("wr_iwait", 32'(s_iwait), 32'd1);
    step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    check("wr_gap_ren", 32'(s_ren | s_wen), 32'd0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hCAFE0001);
    check("wr_then_fetch_addr", s_addr, 32'h104);
    check("wr_then_fetch_iwait", 32'(s_iwait), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    $display("scenario write_priority done");

    // RAM error on a data read.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ERROR, 32'h11111111);
    check("err_dload", s_dload, 32'hBAD1BAD1);
    check("err_dwait", 32'(s_dwait), 32'd0);
    check("err_memerr", 32'(s_err), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h0);
    check("err_pulse_end", 32'(s_err), 32'd0);
    $display("scenario ram_error done");

    // Data request dropped mid-access: no completion, fetch follows.
    do_reset();
    step(1'b1, 32'h500, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
    step(1'b1, 32'h500, 1'b1, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
    check("abort_grant_ren", 32'(s_ren), 32'd1);
    step(1'b1, 32'h500, 1'b0, 1'b0, 32'h300, 32'h0, ACCESS, 32'h1234);
    check("abort_dwait", 32'(s_dwait), 32'd1);
    step(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    check("abort_ren_low", 32'(s_ren), 32'd0);
    step(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h5555);
    check("abort_fetch_addr", s_addr, 32'h500);
    check("abort_fetch_iload", s_iload, 32'h5555);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    $display("scenario abort done");

    // Continuous data and fetch traffic: the guard lets every fifth grant
    // go to the fetch; without it the fetch never wins.
    do_reset();
    grants = 0;
    fetches = 0;
    for (int c = 0; c < 50; c++) begin
      step(1'b1, 32'h500, 1'b1, 1'b0, 32'h400, 32'h0, ACCESS, $urandom);
      if (s_ren) begin
        exp_fetch = GUARD && ((grants % 5) == 4);
        check("starve_kind", 32'(s_addr == 32'h500), 32'(exp_fetch));
        if (s_addr == 32'h500) fetches++;
        grants++;
      end
    end
    check("starve_grants", 32'(grants), 32'd25);
    check("starve_fetches", 32'(fetches), GUARD ? 32'd5 : 32'd0);
    $display("scenario starvation done: %0d grants, %0d fetches", grants, fetches);

    // Randomized traffic; requests tend to persist so accesses complete.
    do_reset();
    r_i = 1'b0; r_d = 1'b0; r_w = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        r_i = 1'($urandom);
        r_d = 1'($urandom);
        r_w = ($urandom_range(0, 2) == 0);
      end
      step(r_i, $urandom, r_d, r_w, $urandom, $urandom, pick_rs(), $urandom);
    end
    $display("scenario random done");

    // Asynchronous reset while a granted access is completing.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0, FREE, 32'h0);
    iREN = 1'b0; dREN = 1'b1; daddr = 32'h900; ramstate = ACCESS; ramload = 32'h77;
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    $display("scenario reset_mid_access done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
